// File: rtl/anita4_scaler_bank_if.sv
// Readout bus for the ANITA-4 scaler bank: an addressed read strobe with
// registered data and a one-cycle valid strobe.
interface anita4_scaler_bank_if #(
  parameter int ADDR_BITS = 5
);
  logic                 rd_i;
  logic [ADDR_BITS-1:0] addr_i;
  logic [31:0]          dat_o;
  logic                 valid_o;

  modport master (output rd_i, output addr_i, input dat_o, input valid_o);
  modport slave  (input rd_i, input addr_i, output dat_o, output valid_o);
endinterface

// File: rtl/anita4_scaler_bank.sv
// ANITA-4 trigger-rate scaler bank.
// NCHAN saturating rate counters with optional 2^PRESCALE prescale, latched
// into hold registers on each PPS rising edge and read back as packed 32-bit
// words (plus a status word at the top address) over an addressed bus.
// Optional feature macro: SCALER_GATE_EN adds the gate_i count inhibit.
module anita4_scaler_bank #(
  parameter int NCHAN     = 32,
  parameter int WIDTH     = 16,
  parameter int PRESCALE  = 0,
  parameter int ADDR_BITS = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NCHAN-1:0] count_i,
  input  logic             pps_i,
`ifdef SCALER_GATE_EN
  input  logic             gate_i,
`endif
  output logic             snap_o,
  anita4_scaler_bank_if.slave bus
);

  localparam int CPW    = 32 / WIDTH;
  localparam int NWORDS = (NCHAN + CPW - 1) / CPW;
  // Keep the prescaler at least one bit wide; it stays at zero when PRESCALE=0.
  localparam int PW     = (PRESCALE > 0) ? PRESCALE : 1;
  localparam logic [ADDR_BITS-1:0] STATUS_ADDR = '1;

  logic [NCHAN-1:0] cnt_r1_q, cnt_r1_d, cnt_r2_q, cnt_r2_d;
  logic             pps_r1_q, pps_r1_d, pps_r2_q, pps_r2_d;
  logic [WIDTH-1:0] ctr_q  [NCHAN];
  logic [WIDTH-1:0] ctr_d  [NCHAN];
  logic [PW-1:0]    pre_q  [NCHAN];
  logic [PW-1:0]    pre_d  [NCHAN];
  logic [WIDTH-1:0] hold_q [NCHAN];
  logic [WIDTH-1:0] hold_d [NCHAN];
  logic [NCHAN-1:0] sat_q, sat_d, hold_sat_q, hold_sat_d;
  logic [15:0]      pps_cnt_q, pps_cnt_d;
  logic             snap_q, snap_d;
  logic [31:0]      dat_q, dat_d;
  logic             valid_q, valid_d;

  logic [NCHAN-1:0] cnt_edge;
  logic             pps_edge;
  logic             count_en;
  logic [31:0]      addr_w;
  logic [31:0]      rd_word;

`ifdef SCALER_GATE_EN
  logic gate_r1_q, gate_r1_d, gate_r2_q, gate_r2_d;

  // Two-flop synchroniser for the count inhibit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gate_r1_q <= 1'b0;
      gate_r2_q <= 1'b0;
    end else begin
      gate_r1_q <= gate_r1_d;
      gate_r2_q <= gate_r2_d;
    end
  end

  assign gate_r1_d = gate_i;
  assign gate_r2_d = gate_r1_q;
  assign count_en  = ~gate_r2_q;
`else
  assign count_en  = 1'b1;
`endif

  // Synchroniser next-state for the asynchronous count and PPS levels.
  always_comb begin
    cnt_r1_d = count_i;
    cnt_r2_d = cnt_r1_q;
    pps_r1_d = pps_i;
    pps_r2_d = pps_r1_q;
  end

  // Edge detect, prescale, saturating count and PPS latch of every channel.
  always_comb begin
    cnt_edge  = cnt_r1_q & ~cnt_r2_q;
    pps_edge  = pps_r1_q & ~pps_r2_q;
    pps_cnt_d = pps_edge ? pps_cnt_q + 16'd1 : pps_cnt_q;
    snap_d    = pps_edge;
    sat_d      = sat_q;
    hold_sat_d = hold_sat_q;
    for (int k = 0; k < NCHAN; k++) begin : g_chan
      logic          edge_ok;
      logic          inc;
      logic [PW-1:0] pre_nxt;
      edge_ok   = cnt_edge[k] & count_en;
      inc       = 1'b0;
      pre_nxt   = pre_q[k];
      ctr_d[k]  = ctr_q[k];
      pre_d[k]  = pre_q[k];
      hold_d[k] = hold_q[k];
      if (edge_ok) begin
        if (PRESCALE == 0) begin
          inc = 1'b1;
        end else begin
          pre_nxt = pre_q[k] + PW'(1);
          inc     = (pre_q[k] == '1);
        end
      end
      if (pps_edge) begin
        // Close the interval: the edge seen in this cycle opens the next one.
        hold_d[k]     = ctr_q[k];
        hold_sat_d[k] = sat_q[k];
        ctr_d[k]      = inc ? WIDTH'(1) : '0;
        sat_d[k]      = 1'b0;
        pre_d[k]      = (PRESCALE != 0 && edge_ok && !inc) ? PW'(1) : '0;
      end else begin
        pre_d[k] = pre_nxt;
        if (inc) begin
          if (ctr_q[k] == '1) sat_d[k] = 1'b1;
          else                ctr_d[k] = ctr_q[k] + WIDTH'(1);
        end
      end
    end
  end

  // Readout mux over the current (pre-update) hold registers.
  always_comb begin
    addr_w  = 32'(bus.addr_i);
    rd_word = '0;
    if (addr_w < 32'(NWORDS)) begin
      for (int k = 0; k < NCHAN; k++) begin
        if (addr_w == 32'(k / CPW)) rd_word[WIDTH*(k%CPW) +: WIDTH] = hold_q[k];
      end
    end else if (bus.addr_i == STATUS_ADDR) begin
      rd_word = {pps_cnt_q, 15'h0, |hold_sat_q};
    end
    dat_d   = bus.rd_i ? rd_word : dat_q;
    valid_d = bus.rd_i;
  end

  // State registers; reset clears everything, including partial counts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r1_q <= '0;
      cnt_r2_q <= '0;
      pps_r1_q <= 1'b0;
      pps_r2_q <= 1'b0;
      for (int k = 0; k < NCHAN; k++) begin
        ctr_q[k]  <= '0;
        pre_q[k]  <= '0;
        hold_q[k] <= '0;
      end
      sat_q      <= '0;
      hold_sat_q <= '0;
      pps_cnt_q  <= '0;
      snap_q     <= 1'b0;
      dat_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      cnt_r1_q   <= cnt_r1_d;
      cnt_r2_q   <= cnt_r2_d;
      pps_r1_q   <= pps_r1_d;
      pps_r2_q   <= pps_r2_d;
      ctr_q      <= ctr_d;
      pre_q      <= pre_d;
      hold_q     <= hold_d;
      sat_q      <= sat_d;
      hold_sat_q <= hold_sat_d;
      pps_cnt_q  <= pps_cnt_d;
      snap_q     <= snap_d;
      dat_q      <= dat_d;
      valid_q    <= valid_d;
    end
  end

  assign snap_o      = snap_q;
  assign bus.dat_o   = dat_q;
  assign bus.valid_o = valid_q;

endmodule

// File: tb/tb_anita4_scaler_bank.sv
// Bench for anita4_scaler_bank: three configurations driven from shared
// stimulus and checked every cycle against a per-interval edge-count model.
module tb_anita4_scaler_bank;

  localparam int NCH [3] = '{32, 12, 4};
  localparam int WD  [3] = '{16, 8, 32};
  localparam int PS  [3] = '{0, 0, 2};
  localparam int AB  [3] = '{5, 3, 3};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cnt = '0;
  logic        pps = 1'b0;
  logic        rd  = 1'b0;
  logic [4:0]  addr = '0;
`ifdef SCALER_GATE_EN
  logic        gate = 1'b0;
  bit          s1g, s2g;
`endif

  int checks = 0;
  int failures = 0;
  int snap_seen = 0;
  bit live = 0;

  logic [31:0] act_dat  [3];
  logic        act_vld  [3];
  logic        act_snap [3];

  // Model state: raw counted edges per channel in the open interval.
  longint      m_raw  [3][32];
  longint      m_hold [3][32];
  bit          m_hsat [3][32];
  int          m_pps  [3];
  logic [31:0] exp_dat  [3];
  bit          exp_vld  [3];
  bit          exp_snap [3];
  logic [31:0] s1c, s2c;
  bit          s1p, s2p;

  always #5 clk = ~clk;

  anita4_scaler_bank_if #(.ADDR_BITS(5)) if0 ();
  anita4_scaler_bank_if #(.ADDR_BITS(3)) if1 ();
  anita4_scaler_bank_if #(.ADDR_BITS(3)) if2 ();

  assign if0.rd_i = rd;
  assign if1.rd_i = rd;
  assign if2.rd_i = rd;
  assign if0.addr_i = addr;
  assign if1.addr_i = addr[2:0];
  assign if2.addr_i = addr[2:0];
  assign act_dat[0] = if0.dat_o;
  assign act_dat[1] = if1.dat_o;
  assign act_dat[2] = if2.dat_o;
  assign act_vld[0] = if0.valid_o;
  assign act_vld[1] = if1.valid_o;
  assign act_vld[2] = if2.valid_o;

  anita4_scaler_bank #(.NCHAN(32), .WIDTH(16), .PRESCALE(0), .ADDR_BITS(5)) u_d0 (
    .clk_i(clk), .rst_i(rst), .count_i(cnt), .pps_i(pps),
`ifdef SCALER_GATE_EN
    .gate_i(gate),
`endif
    .snap_o(act_snap[0]), .bus(if0));

  anita4_scaler_bank #(.NCHAN(12), .WIDTH(8), .PRESCALE(0), .ADDR_BITS(3)) u_d1 (
    .clk_i(clk), .rst_i(rst), .count_i(cnt[11:0]), .pps_i(pps),
`ifdef SCALER_GATE_EN
    .gate_i(gate),
`endif
    .snap_o(act_snap[1]), .bus(if1));

  anita4_scaler_bank #(.NCHAN(4), .WIDTH(32), .PRESCALE(2), .ADDR_BITS(3)) u_d2 (
    .clk_i(clk), .rst_i(rst), .count_i(cnt[3:0]), .pps_i(pps),
`ifdef SCALER_GATE_EN
    .gate_i(gate),
`endif
    .snap_o(act_snap[2]), .bus(if2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Packed readout word a of configuration d, built from the model holds.
  function automatic logic [31:0] mword(input int d, input int a);
    int cpw, nw;
    logic [31:0] w;
    bit anys;
    cpw = 32 / WD[d];
    nw = (NCH[d] + cpw - 1) / cpw;
    w = '0;
    anys = 0;
    for (int k = 0; k < NCH[d]; k++) anys |= m_hsat[d][k];
    if (a < nw) begin
      for (int k = 0; k < NCH[d]; k++)
        if (k / cpw == a) w = w | 32'(m_hold[d][k] << (WD[d] * (k % cpw)));
    end else if (a == (1 << AB[d]) - 1) begin
      w = {16'(m_pps[d]), 15'h0, anys};
    end
    return w;
  endfunction

  // Reference model: an input rise is seen two clocks later; each interval's
  // hold is min(edges >> PRESCALE, 2^WIDTH-1).
  always @(posedge clk) begin
    bit gated;
    live = 1;
    if (rst) begin
      for (int d = 0; d < 3; d++) begin
        for (int k = 0; k < 32; k++) begin
          m_raw[d][k] = 0; m_hold[d][k] = 0; m_hsat[d][k] = 0;
        end
        m_pps[d] = 0; exp_dat[d] = '0; exp_vld[d] = 0; exp_snap[d] = 0;
      end
      s1c = '0; s2c = '0; s1p = 0; s2p = 0;
`ifdef SCALER_GATE_EN
      s1g = 0; s2g = 0;
`endif
    end else begin
      logic [31:0] ce;
      bit pe;
      ce = s1c & ~s2c;
      pe = s1p & ~s2p;
      gated = 0;
`ifdef SCALER_GATE_EN
      gated = s2g;
`endif
      for (int d = 0; d < 3; d++) begin
        longint maxv, incs;
        maxv = (longint'(1) << WD[d]) - 1;
        if (rd) begin
          exp_dat[d] = mword(d, int'(addr) & ((1 << AB[d]) - 1));
          exp_vld[d] = 1;
        end else begin
          exp_vld[d] = 0;
        end
        exp_snap[d] = pe;
        for (int k = 0; k < NCH[d]; k++) begin
          bit ok;
          ok = ce[k] && !gated;
          if (pe) begin
            incs = m_raw[d][k] >> PS[d];
            m_hold[d][k] = (incs > maxv) ? maxv : incs;
            m_hsat[d][k] = (incs > maxv);
            if (!ok) m_raw[d][k] = 0;
            else if (((m_raw[d][k] + 1) % (longint'(1) << PS[d])) == 0)
              m_raw[d][k] = longint'(1) << PS[d];
            else m_raw[d][k] = 1;
          end else if (ok) begin
            m_raw[d][k] = m_raw[d][k] + 1;
          end
        end
        if (pe) m_pps[d] = (m_pps[d] + 1) & 16'hFFFF;
      end
      s2c = s1c; s1c = cnt;
      s2p = s1p; s1p = pps;
`ifdef SCALER_GATE_EN
      s2g = s1g; s1g = gate;
`endif
    end
  end

  // Compare every DUT output against the model away from the clock edge.
  always @(negedge clk) begin
    if (live) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("d%0d_dat", d), act_dat[d], exp_dat[d]);
        chk($sformatf("d%0d_valid", d), 32'(act_vld[d]), 32'(exp_vld[d]));
        chk($sformatf("d%0d_snap", d), 32'(act_snap[d]), 32'(exp_snap[d]));
      end
      if (act_snap[0]) snap_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    cnt = '0; pps = 0; rd = 0; rst = 1;
    tick(2);
    rst = 0;
    tick(1);
  endtask

  task automatic edges(input logic [31:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      cnt = m; tick(1);
      cnt = '0; tick(1);
    end
    tick(2);
  endtask

  task automatic pps_pulse();
    pps = 1; tick(2);
    pps = 0; tick(4);
  endtask

  task automatic read_at(input int a);
    rd = 1; addr = 5'(a);
    tick(1);
    rd = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    do_reset();
    chk("reset_dat", act_dat[0], 32'h0);
    chk("reset_valid", 32'(act_vld[0]), 32'h0);

    // 100 edges on ch0, 7 on ch1, then PPS.
    for (int i = 0; i < 100; i++) begin
      cnt = (i < 7) ? 32'h3 : 32'h1; tick(1);
      cnt = '0; tick(1);
    end
    tick(2);
    snap_seen = 0;
    pps_pulse();
    chk("t1_snap_pulses", 32'(snap_seen), 32'd1);
    read_at(0);
    chk("t1_d0_word0", act_dat[0], 32'h0007_0064);
    chk("t1_d0_valid", 32'(act_vld[0]), 32'd1);
    chk("t1_d1_word0", act_dat[1], 32'h0000_0764);
    chk("t1_d2_word0", act_dat[2], 32'h0000_0019);
    tick(1);
    chk("t1_valid_drop", 32'(act_vld[0]), 32'd0);
    chk("t1_dat_hold", act_dat[0], 32'h0007_0064);

    // Saturation of an 8-bit channel, then an empty interval.
    do_reset();
    edges(32'h20, 300);
    pps_pulse();
    read_at(1);
    chk("sat_d1_lane", 32'(act_dat[1][15:8]), 32'hFF);
    chk("sat_d1_word1", act_dat[1], 32'h0000_FF00);
    read_at(7);
    chk("sat_d1_status", act_dat[1], 32'h0001_0001);
    pps_pulse();
    read_at(1);
    chk("sat_d1_word1_empty", act_dat[1], 32'h0);
    read_at(7);
    chk("sat_d1_status_clr", act_dat[1], 32'h0002_0000);

    // Prescale by 4: residual edges do not carry across PPS.
    do_reset();
    edges(32'h8, 10);
    pps_pulse();
    read_at(3);
    chk("pre_d2_ch3", act_dat[2], 32'd2);
    edges(32'h8, 2);
    pps_pulse();
    read_at(3);
    chk("pre_d2_residual", act_dat[2], 32'd0);

    // Count edge in the PPS-edge cycle belongs to the new interval.
    do_reset();
    cnt = 32'h4; pps = 1; tick(2);
    cnt = '0; pps = 0; tick(4);
    read_at(1);
    chk("same_old", act_dat[0], 32'h0);
    pps_pulse();
    read_at(1);
    chk("same_new", act_dat[0], 32'h1);

    // Interval counter, unmapped address, reset mid-interval.
    do_reset();
    pps_pulse(); pps_pulse(); pps_pulse();
    read_at(31);
    chk("status_d0", act_dat[0], 32'h0003_0000);
    chk("status_d1", act_dat[1], 32'h0003_0000);
    chk("status_d2", act_dat[2], 32'h0003_0000);
    read_at(16);
    chk("unmapped_d0", act_dat[0], 32'h0);
    edges(32'hFFFF_FFFF, 5);
    rst = 1; tick(1); rst = 0; tick(1);
    pps_pulse();
    read_at(0);
    chk("rst_mid_d0", act_dat[0], 32'h0);
    chk("rst_mid_d1", act_dat[1], 32'h0);

    // Reset coinciding with a read suppresses valid.
    rd = 1; addr = 5'd31; rst = 1;
    tick(1);
    rd = 0; rst = 0;
    chk("rst_rd_valid", 32'(act_vld[0]), 32'd0);
    tick(2);

`ifdef SCALER_GATE_EN
    // Gated edges are not counted.
    do_reset();
    gate = 1; tick(3);
    edges(32'h1, 50);
    gate = 0; tick(3);
    edges(32'h1, 20);
    pps_pulse();
    read_at(0);
    chk("gate_d0", act_dat[0], 32'd20);
    chk("gate_d2", act_dat[2], 32'd5);
`endif

    // Randomised traffic checked by the model every cycle.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      cnt  = cnt ^ ($urandom & $urandom & $urandom);
      if ($urandom_range(0, 80) == 0) pps = ~pps;
      rd   = ($urandom_range(0, 3) == 0);
      addr = 5'($urandom);
      rst  = ($urandom_range(0, 500) == 0);
`ifdef SCALER_GATE_EN
      if ($urandom_range(0, 40) == 0) gate = ~gate;
`endif
      tick(1);
    end
    rst = 0; rd = 0;
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/anita4_scaler_bank.md
Name: anita4_scaler_bank

Overview:
- Parametrised trigger-rate scaler bank: NCHAN independent 1 s rate counters, latched on PPS, read back as packed 32-bit words over an addressed bus.
- Generalises the fixed 8/16-bit per-type scalers to arbitrary channel count, counter width and prescale.
- Adds saturation flags, an interval counter and registered readout with a valid strobe.
- Sits between L1/L3 trigger outputs and the TURF register readout mux.

Parameters:
- NCHAN, 32, number of scaler channels (1..64).
- WIDTH, 16, counter/hold width per channel; legal values 8, 16, 32.
- PRESCALE, 0, counter increments once per 2^PRESCALE counted edges (0..8).
- ADDR_BITS, 5, readout address width; 2^ADDR_BITS must be ≥ NWORDS+1.

Ports:
- clk_i  in  1  system clock (33 MHz domain).
- rst_i  in  1  synchronous active-high reset.
- count_i  in  NCHAN  asynchronous level inputs; each rising edge is one count.
- pps_i  in  1  asynchronous PPS level; rising edge closes the interval.
- gate_i  in  1  count inhibit (only with SCALER_GATE_EN).
- rd_i  in  1  read strobe.
- addr_i  in  ADDR_BITS  word address, sampled with rd_i.
- dat_o  out  32  read data.
- valid_o  out  1  one-cycle strobe qualifying dat_o.
- snap_o  out  1  one-cycle pulse when the hold registers update.

Behaviour:
- Derived constants:
  - CPW = 32/WIDTH channels per word.
  - NWORDS = ceil(NCHAN/CPW).
  - STATUS_ADDR = 2^ADDR_BITS-1.
- Input conditioning:
  - count_i and pps_i each pass through two flops (r1, r2).
  - edge = r1 & ~r2.
  - A level toggle on an input appears as an edge 2 cycles later.
  - A level held high counts once.
- Per channel, on edge:
  - The prescaler (PRESCALE bits) increments.
  - On prescaler wrap, or every edge when PRESCALE=0, the counter increments.
  - The counter saturates at 2^WIDTH-1 and never wraps.
  - The channel sat flag sets when an increment is attempted at all-ones.
- On PPS edge (same cycle as edge detect):
  - hold[k] <= counter[k] (saturated value), and hold_sat[k] <= sat[k].
  - The counter restarts at 0, or at 1 if that channel's increment fires in the same cycle, so no count is lost or double counted.
  - sat and the prescaler residuals clear.
  - pps_cnt (16 bits, wrapping) increments.
  - snap_o pulses 1 cycle later, concurrent with hold being visible.
- Readout has 1-cycle latency: rd_i in cycle n gives dat_o/valid_o in cycle n+1.
  - dat_o holds its value until the next rd_i.
  - valid_o is high only in cycle n+1.
- Word packing: channel k is at word k/CPW, bits [WIDTH*(k%CPW) +: WIDTH]. Unused lanes in the last word read 0.
- Address map:
  - addr < NWORDS: packed holds.
  - addr = STATUS_ADDR: {pps_cnt[15:0], 15'h0, |hold_sat}.
  - Any other address reads 0.
- Read in the same cycle as a hold update returns the pre-update hold values; words are never torn.
- Reset:
  - Counters, prescalers, holds, sat flags, pps_cnt and sync flops clear.
  - dat_o=0, valid_o=0, snap_o=0.
  - A reset asserted mid-interval discards the partial counts.
  - A reset asserted while rd_i is pending suppresses valid_o.
- pps_i and rst_i in the same cycle: reset wins.

Optional Feature:
- SCALER_GATE_EN defined:
  - gate_i (synchronised through two flops) high suppresses counter and prescaler increments.
  - PPS handling is unaffected.
  - Used for deadtime-excluded rates.
- Undefined:
  - gate_i port is absent and every edge counts.

Test Plan:
- NCHAN=32, WIDTH=16: 100 edges on ch0, 7 on ch1, then PPS -> addr 0 reads 0x0007_0064 with valid_o 1 cycle after rd_i; snap_o pulses once.
- WIDTH=8, 300 edges on ch5 -> word 1, bits[15:8] = 0xFF; STATUS bit0 = 1; after the next empty interval, word reads 0 and bit0 = 0.
- PRESCALE=2, 10 edges on ch3 -> hold = 2; the 2 residual edges do not carry into the next interval.
- Count edge on ch2 in the exact PPS-edge cycle -> old interval excludes it, new interval hold = 1.
- Three PPS edges -> STATUS_ADDR reads 0x0003_0000; addr NWORDS reads 0; rst_i mid-interval then PPS -> all holds 0.
- SCALER_GATE_EN: 50 edges with gate_i high, 20 with it low -> hold = 20.
